// File: rtl/ga_pkg.sv
// Shared GA datapath definitions: LFSR constants, mutator FSM states, gene slicing.
package ga_pkg;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  typedef enum logic [2:0] {
    IDLE,
    PICK_A,
    PICK_B,
    SWAP,
    DONE
  } mut_state_e;

  // LSB position of gene idx inside a packed chromosome
  function automatic int gene_lsb(input int idx, input int gene_w);
    return idx * gene_w;
  endfunction
endpackage

// File: rtl/swap_mutator_multi_if.sv
// Start/done bus between parent selection and the swap mutator.
interface swap_mutator_multi_if #(
  parameter int GENE_W    = 5,
  parameter int NUM_GENES = 30,
  parameter int CNT_W     = 4
) ();
  logic                        start;
  logic                        seed_load;
  logic [31:0]                 prg_seed;
  logic [CNT_W-1:0]            swap_count;
  logic [GENE_W*NUM_GENES-1:0] parent;
  logic [GENE_W*NUM_GENES-1:0] mutant;
  logic                        busy;
  logic                        done;

  modport master (output start, seed_load, prg_seed, swap_count, parent,
                  input  mutant, busy, done);
  modport slave  (input  start, seed_load, prg_seed, swap_count, parent,
                  output mutant, busy, done);
endinterface

// File: rtl/ga_lfsr32.sv
// 32-bit Galois LFSR with seed load; a zero seed is forced to the reset value.
module ga_lfsr32
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       value <= LFSR_RESET;
    else if (load)    value <= (seed == 32'h0) ? LFSR_RESET : seed;
    else if (advance) value <= value[0] ? ((value >> 1) ^ LFSR_POLY) : (value >> 1);
  end
endmodule

// File: rtl/swap_mutator_multi.sv
// Multi-swap mutator: performs swap_count random gene-pair swaps on a captured parent.
module swap_mutator_multi
  import ga_pkg::*;
#(
  parameter int GENE_W    = 5,
  parameter int NUM_GENES = 30,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  swap_mutator_multi_if.slave  bus
);
  localparam int W = GENE_W * NUM_GENES;

  mut_state_e       state, state_n;
  logic [W-1:0]     work, swapped, mutant_q;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_a, idx_b, cand;
  logic [GENE_W-1:0] gene_a, gene_b;
  logic [31:0]      lfsr;
  logic             cand_ok;
  logic             unused_lfsr_hi;

  ga_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == IDLE && bus.seed_load),
    .seed    (bus.prg_seed),
    .advance (state == PICK_A || state == PICK_B),
    .value   (lfsr)
  );

  // Only the low IDX_W bits form a candidate; the rest is LFSR state
  assign cand           = lfsr[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr[31:IDX_W];
  assign cand_ok        = 32'(cand) < NUM_GENES;

  always_comb begin
    gene_a  = work[gene_lsb(int'(idx_a), GENE_W) +: GENE_W];
    gene_b  = work[gene_lsb(int'(idx_b), GENE_W) +: GENE_W];
    swapped = work;
    swapped[gene_lsb(int'(idx_a), GENE_W) +: GENE_W] = gene_b;
    swapped[gene_lsb(int'(idx_b), GENE_W) +: GENE_W] = gene_a;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = (bus.swap_count == '0) ? DONE : PICK_A;
      PICK_A:  if (cand_ok) state_n = PICK_B;
      PICK_B:  if (cand_ok) state_n = SWAP;
      SWAP:    state_n = (cnt == CNT_W'(1)) ? DONE : PICK_A;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      idx_a    <= '0;
      idx_b    <= '0;
      mutant_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE:   if (bus.start) begin
                  work <= bus.parent;
                  cnt  <= bus.swap_count;
                end
        PICK_A: if (cand_ok) idx_a <= cand;
        PICK_B: if (cand_ok) idx_b <= cand;
        SWAP:   begin
                  work <= swapped;
                  cnt  <= cnt - CNT_W'(1);
                end
        DONE:   mutant_q <= work;
        default: ;
      endcase
    end
  end

  assign bus.mutant = mutant_q;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_swap_mutator_multi.sv
// Scoreboard bench for swap_mutator_multi: stimulus pushes model results, monitor checks on done.
module tb_swap_mutator_multi;
  import ga_pkg::*;
  localparam int GW = 5, NG = 30, IW = 5, CW = 4, W = GW * NG;
  localparam logic [31:0] SEED_A = 32'd3124684136;
  localparam logic [31:0] SEED_R = 32'hDEAD_BEFF;

  typedef struct {
    logic [W-1:0] mut;
    int           lat;
    int           start_cyc;
    string        name;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  int   cyc = 0, n_chk = 0, n_fail = 0, n_done = 0, exp_done = 0;
  exp_t sb[$];

  swap_mutator_multi_if #(.GENE_W(GW), .NUM_GENES(NG), .CNT_W(CW)) bus ();
  swap_mutator_multi #(.GENE_W(GW), .NUM_GENES(NG), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  function automatic logic [31:0] step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic void model(input logic [31:0] seed, input logic [W-1:0] par, input int cnt,
                                output logic [W-1:0] mut, output int lat,
                                output int ia, output int ib, output int rej);
    logic [31:0] l;
    logic [GW-1:0] t;
    int c, sel[2];
    l = (seed == 0) ? 32'h1 : seed;
    mut = par; lat = 1; rej = 0; ia = 0; ib = 0;
    for (int k = 0; k < cnt; k++) begin
      for (int p = 0; p < 2; p++) begin
        c = int'(l[4:0]); l = step(l); lat++;
        while (c >= NG) begin
          c = int'(l[4:0]); l = step(l); lat++; rej++;
        end
        sel[p] = c;
      end
      ia = sel[0]; ib = sel[1];
      t = mut[ia*GW +: GW];
      mut[ia*GW +: GW] = mut[ib*GW +: GW];
      mut[ib*GW +: GW] = t;
      lat++;
    end
  endfunction

  int m_ia, m_ib, m_rej, m_lat;
  logic [W-1:0] m_mut;

  task automatic start_run(input string nm, input logic [31:0] seed, input logic [W-1:0] par,
                           input int cnt, input bit push);
    exp_t e;
    @(negedge clk);
    model(seed, par, cnt, m_mut, m_lat, m_ia, m_ib, m_rej);
    if (push) begin
      e.mut = m_mut; e.lat = m_lat; e.start_cyc = cyc + 1; e.name = nm;
      sb.push_back(e);
      exp_done++;
    end
    bus.start = 1'b1; bus.seed_load = 1'b1; bus.prg_seed = seed;
    bus.parent = par; bus.swap_count = CW'(cnt);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.seed_load = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    check({nm, "_idle_timeout"}, W'(ok), W'(1));
  endtask

  // Monitor: done is a single-cycle pulse; mutant is registered at the end of it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: done seen at cycle %0d with no pending run", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, W'(cyc - e.start_cyc + 1), W'(e.lat));
          @(negedge clk);
          check({e.name, "_done_pulse"}, W'(bus.done), W'(0));
          check({e.name, "_busy_fall"}, W'(bus.busy), W'(0));
          check({e.name, "_mutant"}, bus.mutant, e.mut);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  logic [W-1:0] pat, ident, other, srt, old_mut;
  int g[NG], ndiff, tmp;

  initial begin
    bus.start = 0; bus.seed_load = 0; bus.prg_seed = 0; bus.swap_count = 0; bus.parent = '0;
    for (int i = 0; i < NG; i++) begin
      pat[i*GW +: GW]   = GW'((i * 11 + 7) % 32);
      ident[i*GW +: GW] = GW'(i);
      other[i*GW +: GW] = GW'((i * 3 + 1) % 32);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    check("rst_mutant", bus.mutant, '0);
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_lfsr", W'(dut.u_lfsr.value), W'(32'h1));

    bus.seed_load = 1; bus.prg_seed = 32'h5;
    @(negedge clk); bus.prg_seed = 32'h0;
    check("seed_5", W'(dut.u_lfsr.value), W'(32'h5));
    @(negedge clk); bus.seed_load = 0;
    check("seed_0_to_1", W'(dut.u_lfsr.value), W'(32'h1));
    check("seed_busy", W'(bus.busy), W'(0));

    start_run("cnt0", SEED_A, pat, 0, 1);
    wait_idle("cnt0");
    check("cnt0_eq_parent", bus.mutant, pat);

    start_run("cnt1", SEED_A, pat, 1, 1);
    wait_idle("cnt1");
    ndiff = 0;
    for (int i = 0; i < NG; i++) if (bus.mutant[i*GW +: GW] != pat[i*GW +: GW]) ndiff++;
    check("cnt1_le2_diff", W'(ndiff <= 2), W'(1));
    check("cnt1_idx_a", W'(dut.idx_a), W'(m_ia));
    check("cnt1_idx_b", W'(dut.idx_b), W'(m_ib));

    start_run("cnt15", SEED_A, ident, 15, 1);
    wait_idle("cnt15");
    for (int i = 0; i < NG; i++) g[i] = int'(bus.mutant[i*GW +: GW]);
    for (int i = 0; i < NG; i++)
      for (int j = 0; j < NG - 1 - i; j++)
        if (g[j] > g[j+1]) begin tmp = g[j]; g[j] = g[j+1]; g[j+1] = tmp; end
    for (int i = 0; i < NG; i++) srt[i*GW +: GW] = GW'(g[i]);
    check("cnt15_permutation", srt, ident);

    // Low 5 bits of SEED_R are 31, so the first PICK_A draw must be rejected
    start_run("reject", SEED_R, pat, 1, 1);
    check("reject_pick_a0", W'(dut.state), W'(PICK_A));
    @(posedge clk); #1;
    check("reject_pick_a1", W'(dut.state), W'(PICK_A));
    check("reject_model_extra", W'(m_lat >= 5), W'(1));
    wait_idle("reject");

    old_mut = bus.mutant;
    start_run("rst_mid", SEED_A, ident, 8, 0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (dut.state == PICK_B) begin hit = 1'b1; break; end
      end
      check("rst_mid_reach_pick_b", W'(hit), W'(1));
    end
    rst_n = 1'b0; #1;
    check("rst_mid_mutant", bus.mutant, '0);
    check("rst_mid_state", W'(dut.state), W'(IDLE));
    check("rst_mid_busy", W'(bus.busy), W'(0));
    check("rst_mid_lfsr", W'(dut.u_lfsr.value), W'(32'h1));
    check("rst_mid_prev_nonzero", W'(old_mut != '0), W'(1));
    @(negedge clk); rst_n = 1'b1;

    start_run("after_rst", SEED_A, other, 0, 1);
    wait_idle("after_rst");

    start_run("busy_ign", SEED_A, pat, 15, 1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.swap_count = '0; bus.parent = other;
    bus.seed_load = 1'b1; bus.prg_seed = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0; bus.seed_load = 1'b0;
    wait_idle("busy_ign");

    repeat (5) @(negedge clk);
    check("done_count", W'(n_done), W'(exp_done));
    check("scoreboard_empty", W'(sb.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
